vjtag_tap: RTL and testbench

Parametrised, oversampled IEEE 1149.1 TAP controller; next generation of the virtual-JTAG state decoder. Samples TCK/TMS/TDI in the `clk` domain, runs the full 16-state TAP machine, and owns the instruction register, the BYPASS and IDCODE data registers, and a USER data-register hook. Sits between the chip's JTAG pins and user scan logic, which no longer needs to implement BYPASS or the IR itself.

---
 rtl/vjtag_tap_if.sv | 46 ++++
 rtl/vjtag_tap.sv | 159 +++++++++++++++
 tb/tb_vjtag_tap.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vjtag_tap_if.sv
// ============================================================================
// vjtag_tap_if : JTAG pin and user-scan bundle for the vjtag_tap controller
// Revision     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface vjtag_tap_if #(
  parameter int IR_LEN = 4
) ();
  logic              tck;
  logic              tms;
  logic              tdi;
  logic              user_tdo;
  logic              tdo;
  logic              tdo_enb;
  logic              tdi_r1;
  logic              tck_rise;
  logic              tck_fall;
  logic [3:0]        state;
  logic [IR_LEN-1:0] ir;
  logic              captureDR;
  logic              shiftDR;
  logic              updateDR;
  logic              captureIR;
  logic              shiftIR;
  logic              updateIR;
  logic              user_sel;
  logic              tlr;

  modport master (
    output tck, tms, tdi, user_tdo,
    input  tdo, tdo_enb, tdi_r1, tck_rise, tck_fall, state, ir,
           captureDR, shiftDR, updateDR, captureIR, shiftIR, updateIR,
           user_sel, tlr
  );

  modport slave (
    input  tck, tms, tdi, user_tdo,
    output tdo, tdo_enb, tdi_r1, tck_rise, tck_fall, state, ir,
           captureDR, shiftDR, updateDR, captureIR, shiftIR, updateIR,
           user_sel, tlr
  );
endinterface

`default_nettype wire

// File: rtl/vjtag_tap.sv
// ============================================================================
// vjtag_tap : oversampled IEEE 1149.1 TAP with IR, BYPASS, IDCODE and USER DR
// Revision  : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module vjtag_tap #(
  parameter int                IR_LEN       = 4,
  parameter logic [31:0]       IDCODE       = 32'h1000_0001,
  parameter logic [IR_LEN-1:0] IDCODE_INSTR = IR_LEN'(1),
  parameter logic [IR_LEN-1:0] USER_INSTR   = IR_LEN'(2),
  parameter int                SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        trst_n,
  vjtag_tap_if.slave  bus
);

  typedef enum logic [3:0] {
    TLR     = 4'hF, RTI     = 4'hC, SELDR   = 4'h7, CAPDR   = 4'h6,
    SHDR    = 4'h2, EX1DR   = 4'h1, PAUSEDR = 4'h3, EX2DR   = 4'h0,
    UPDDR   = 4'h5, SELIR   = 4'h4, CAPIR   = 4'hE, SHIR    = 4'hA,
    EX1IR   = 4'h9, PAUSEIR = 4'hB, EX2IR   = 4'h8, UPDIR   = 4'hD
  } tap_state_e;

  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  tap_state_e             state_q, state_d, state_nxt;
  logic [IR_LEN-1:0]      ir_q, ir_d;
  logic [IR_LEN-1:0]      ir_sr_q, ir_sr_d;
  logic [31:0]            id_sr_q, id_sr_d;
  logic                   bypass_q, bypass_d;
  logic                   tdo_q, tdo_d;
  logic                   tdo_enb_q, tdo_enb_d;
  logic                   tdi_r1_q, tdi_r1_d;

  logic synced, tck_rise, tck_fall, id_sel, user_sel, dr_bit;

  assign synced   = sync_q[SYNC_STAGES-1];
  assign tck_rise = synced & ~hist_q;
  assign tck_fall = ~synced & hist_q;
  assign id_sel   = (ir_q == IDCODE_INSTR);
  assign user_sel = (ir_q == USER_INSTR) && !id_sel;
  assign dr_bit   = id_sel ? id_sr_q[0] : (user_sel ? bus.user_tdo : bypass_q);

  always_comb begin
    state_nxt = TLR;
    unique case (state_q)
      TLR:     state_nxt = bus.tms ? TLR   : RTI;
      RTI:     state_nxt = bus.tms ? SELDR : RTI;
      SELDR:   state_nxt = bus.tms ? SELIR : CAPDR;
      CAPDR:   state_nxt = bus.tms ? EX1DR : SHDR;
      SHDR:    state_nxt = bus.tms ? EX1DR : SHDR;
      EX1DR:   state_nxt = bus.tms ? UPDDR : PAUSEDR;
      PAUSEDR: state_nxt = bus.tms ? EX2DR : PAUSEDR;
      EX2DR:   state_nxt = bus.tms ? UPDDR : SHDR;
      UPDDR:   state_nxt = bus.tms ? SELDR : RTI;
      SELIR:   state_nxt = bus.tms ? TLR   : CAPIR;
      CAPIR:   state_nxt = bus.tms ? EX1IR : SHIR;
      SHIR:    state_nxt = bus.tms ? EX1IR : SHIR;
      EX1IR:   state_nxt = bus.tms ? UPDIR : PAUSEIR;
      PAUSEIR: state_nxt = bus.tms ? EX2IR : PAUSEIR;
      EX2IR:   state_nxt = bus.tms ? UPDIR : SHIR;
      UPDIR:   state_nxt = bus.tms ? SELDR : RTI;
      default: state_nxt = TLR;
    endcase
  end

  // Register actions act on the state held before this TCK edge is applied.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.tck};
    hist_d    = synced;
    state_d   = state_q;
    ir_d      = ir_q;
    ir_sr_d   = ir_sr_q;
    id_sr_d   = id_sr_q;
    bypass_d  = bypass_q;
    tdo_d     = tdo_q;
    tdo_enb_d = tdo_enb_q;
    tdi_r1_d  = tdi_r1_q;

    if (tck_rise) begin
      state_d  = state_nxt;
      tdi_r1_d = bus.tdi;
      case (state_q)
        CAPIR: ir_sr_d = IR_CAPTURE;
        SHIR:  ir_sr_d = {bus.tdi, ir_sr_q[IR_LEN-1:1]};
        CAPDR: begin
          bypass_d = 1'b0;
          if (id_sel) id_sr_d = IDCODE;
        end
        SHDR: begin
          bypass_d = bus.tdi;
          if (id_sel) id_sr_d = {bus.tdi, id_sr_q[31:1]};
        end
        default: ;
      endcase
    end

    if (tck_fall) begin
      if (state_q == UPDIR) ir_d = ir_sr_q;
      if (state_q == SHIR)
        tdo_d = ir_sr_q[0];
      else if (state_q == SHDR)
        tdo_d = dr_bit;
      tdo_enb_d = (state_q == SHIR) || (state_q == SHDR);
    end

    if (state_q == TLR) ir_d = IDCODE_INSTR;
  end

  always_ff @(posedge clk) begin
    if (!trst_n) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      state_q   <= TLR;
      ir_q      <= IDCODE_INSTR;
      ir_sr_q   <= '0;
      id_sr_q   <= '0;
      bypass_q  <= 1'b0;
      tdo_q     <= 1'b0;
      tdo_enb_q <= 1'b0;
      tdi_r1_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      state_q   <= state_d;
      ir_q      <= ir_d;
      ir_sr_q   <= ir_sr_d;
      id_sr_q   <= id_sr_d;
      bypass_q  <= bypass_d;
      tdo_q     <= tdo_d;
      tdo_enb_q <= tdo_enb_d;
      tdi_r1_q  <= tdi_r1_d;
    end
  end

  assign bus.tdo       = tdo_q;
  assign bus.tdo_enb   = tdo_enb_q;
  assign bus.tdi_r1    = tdi_r1_q;
  assign bus.tck_rise  = tck_rise;
  assign bus.tck_fall  = tck_fall;
  assign bus.state     = state_q;
  assign bus.ir        = ir_q;
  assign bus.captureDR = (state_q == CAPDR);
  assign bus.shiftDR   = (state_q == SHDR);
  assign bus.updateDR  = (state_q == UPDDR);
  assign bus.captureIR = (state_q == CAPIR);
  assign bus.shiftIR   = (state_q == SHIR);
  assign bus.updateIR  = (state_q == UPDIR);
  assign bus.user_sel  = user_sel;
  assign bus.tlr       = (state_q == TLR);

endmodule

`default_nettype wire

// File: tb/tb_vjtag_tap.sv
// ============================================================================
// tb_vjtag_tap : directed self-checking bench for vjtag_tap
// Revision     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vjtag_tap;
  logic clk = 1'b0;
  logic trst_n = 1'b0;
  always #5 clk = ~clk;

  vjtag_tap_if #(.IR_LEN(4)) jif ();

  vjtag_tap #(
    .IR_LEN(4), .IDCODE(32'h1000_0001), .IDCODE_INSTR(4'b0001),
    .USER_INSTR(4'b0010), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .trst_n(trst_n), .bus(jif.slave)
  );

  int total = 0;
  int bad = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  int upd_cnt = 0;

  always @(posedge clk) begin
    if (jif.tck_rise === 1'b1) rise_cnt++;
    if (jif.tck_fall === 1'b1) fall_cnt++;
    if (jif.updateDR === 1'b1 && jif.tck_fall === 1'b1) upd_cnt++;
  end

  // Navigation table applied from RTI (a leading TMS=0 is harmless there).
  logic [7:0] pb [16] = '{8'b0, 8'b10, 8'b010, 8'b0010, 8'b1010, 8'b01010,
                          8'b101010, 8'b11010, 8'b110, 8'b0110, 8'b00110,
                          8'b10110, 8'b010110, 8'b1010110, 8'b110110, 8'b111};
  int         pl [16] = '{1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6, 3};
  logic [3:0] pe [16] = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0, 4'h5,
                          4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD, 4'hF};

  task automatic pulse(input logic m, input logic d);
    @(negedge clk);
    jif.tms = m;
    jif.tdi = d;
    repeat (4) @(negedge clk);
    jif.tck = 1'b1;
    repeat (6) @(negedge clk);
    jif.tck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    trst_n = 1'b0;
    jif.tck = 1'b0;
    repeat (2) @(negedge clk);
    trst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    trst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      jif.tck = 1'($urandom_range(0, 1));
      jif.tms = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      total++;
      if ({jif.tck_rise, jif.tck_fall} !== 2'b00) begin
        bad++;
        $display("FAIL reset_strobes: got %b expected 00", {jif.tck_rise, jif.tck_fall});
      end
    end
    total++;
    if ({jif.state, jif.ir, jif.tdo, jif.tdo_enb, jif.tlr, jif.user_sel} !== {4'hF, 4'h1, 4'b0010}) begin
      bad++;
      $display("FAIL reset_values: state=%h ir=%h tdo=%b enb=%b tlr=%b usel=%b expected F 1 0 0 1 0",
               jif.state, jif.ir, jif.tdo, jif.tdo_enb, jif.tlr, jif.user_sel);
    end
    // Release with TCK already high: exactly one rise must be seen.
    @(negedge clk);
    jif.tck = 1'b1;
    jif.tms = 1'b0;
    @(negedge clk);
    rise_cnt = 0;
    trst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (rise_cnt !== 1 || jif.state !== 4'hC) begin
      bad++;
      $display("FAIL reset_tck_high: rises=%0d state=%h expected 1 C", rise_cnt, jif.state);
    end
    jif.tck = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_tlr_all();
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < pl[k]; j++) pulse(pb[k][j], 1'b0);
      total++;
      if (jif.state !== pe[k]) begin
        bad++;
        $display("FAIL nav_%0d: state=%h expected %h", k, jif.state, pe[k]);
      end
      for (int j = 0; j < 5; j++) pulse(1'b1, 1'b0);
      total++;
      if (jif.state !== 4'hF) begin
        bad++;
        $display("FAIL tlr_from_%h: state=%h expected F", pe[k], jif.state);
      end
      pulse(1'b0, 1'b0);
      total++;
      if (jif.state !== 4'hC) begin
        bad++;
        $display("FAIL rti_after_%h: state=%h expected C", pe[k], jif.state);
      end
    end
  endtask

  task automatic test_idcode();
    logic [31:0] exp_id;
    exp_id = 32'h1000_0001;
    do_reset();
    pulse(1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    total++;
    if (jif.tdo_enb !== 1'b0) begin
      bad++;
      $display("FAIL id_enb_capdr: got %b expected 0", jif.tdo_enb);
    end
    pulse(1'b0, 1'b0);
    total++;
    if (jif.state !== 4'h2 || jif.tdo_enb !== 1'b1) begin
      bad++;
      $display("FAIL id_enter_shdr: state=%h enb=%b expected 2 1", jif.state, jif.tdo_enb);
    end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (jif.tdo !== exp_id[i]) begin
        bad++;
        $display("FAIL id_bit_%0d: got %b expected %b", i, jif.tdo, exp_id[i]);
      end
      pulse(i == 31, 1'b0);
    end
    total++;
    if (jif.tdo_enb !== 1'b0 || jif.state !== 4'h1) begin
      bad++;
      $display("FAIL id_exit: enb=%b state=%h expected 0 1", jif.tdo_enb, jif.state);
    end
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
  endtask

  task automatic test_ir_bypass();
    logic [3:0] exp_cap;
    logic [4:0] pat;
    exp_cap = 4'b0001;
    pat     = 5'b10110;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    total++;
    if (jif.state !== 4'hA || jif.tdo_enb !== 1'b1) begin
      bad++;
      $display("FAIL ir_enter_shir: state=%h enb=%b expected A 1", jif.state, jif.tdo_enb);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (jif.tdo !== exp_cap[i]) begin
        bad++;
        $display("FAIL ir_cap_bit_%0d: got %b expected %b", i, jif.tdo, exp_cap[i]);
      end
      pulse(i == 3, 1'b1);
    end
    pulse(1'b1, 1'b0);
    total++;
    if (jif.ir !== 4'hF || jif.user_sel !== 1'b0) begin
      bad++;
      $display("FAIL ir_load_f: ir=%h usel=%b expected F 0", jif.ir, jif.user_sel);
    end
    pulse(1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    total++;
    if (jif.tdo !== 1'b0 || jif.tdo_enb !== 1'b1) begin
      bad++;
      $display("FAIL byp_capture: tdo=%b enb=%b expected 0 1", jif.tdo, jif.tdo_enb);
    end
    for (int i = 0; i < 5; i++) begin
      pulse(1'b0, pat[i]);
      total++;
      if (jif.tdo !== pat[i] || jif.tdi_r1 !== pat[i]) begin
        bad++;
        $display("FAIL byp_echo_%0d: tdo=%b tdi_r1=%b expected %b", i, jif.tdo, jif.tdi_r1, pat[i]);
      end
    end
    pulse(1'b1, 1'b0);
    total++;
    if (jif.tdo_enb !== 1'b0 || jif.tdo !== 1'b1) begin
      bad++;
      $display("FAIL byp_exit: enb=%b tdo=%b expected 0 1", jif.tdo_enb, jif.tdo);
    end
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
  endtask

  task automatic test_user();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    total++;
    if (jif.ir !== 4'h2 || jif.user_sel !== 1'b1) begin
      bad++;
      $display("FAIL user_load: ir=%h usel=%b expected 2 1", jif.ir, jif.user_sel);
    end
    pulse(1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    jif.user_tdo = 1'b1;
    pulse(1'b0, 1'b0);
    total++;
    if (jif.tdo !== 1'b1) begin
      bad++;
      $display("FAIL user_tdo_a: got %b expected 1", jif.tdo);
    end
    jif.user_tdo = 1'b0;
    pulse(1'b0, 1'b0);
    total++;
    if (jif.tdo !== 1'b0) begin
      bad++;
      $display("FAIL user_tdo_b: got %b expected 0", jif.tdo);
    end
    jif.user_tdo = 1'b1;
    pulse(1'b0, 1'b0);
    total++;
    if (jif.tdo !== 1'b1) begin
      bad++;
      $display("FAIL user_tdo_c: got %b expected 1", jif.tdo);
    end
    pulse(1'b1, 1'b0);
    upd_cnt = 0;
    pulse(1'b1, 1'b0);
    rise_cnt = 0;
    fall_cnt = 0;
    pulse(1'b0, 1'b0);
    total++;
    if (upd_cnt !== 1) begin
      bad++;
      $display("FAIL user_update_pulse: got %0d expected 1", upd_cnt);
    end
    total++;
    if (rise_cnt !== 1 || fall_cnt !== 1) begin
      bad++;
      $display("FAIL strobe_count: rise=%0d fall=%0d expected 1 1", rise_cnt, fall_cnt);
    end
    jif.user_tdo = 1'b0;
  endtask

  task automatic test_reset_mid_ir();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    total++;
    if (jif.state !== 4'hA || jif.tdo_enb !== 1'b1) begin
      bad++;
      $display("FAIL mid_in_shir: state=%h enb=%b expected A 1", jif.state, jif.tdo_enb);
    end
    @(negedge clk);
    trst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({jif.state, jif.ir, jif.tdo_enb, jif.tdo, jif.tlr} !== {4'hF, 4'h1, 3'b001}) begin
      bad++;
      $display("FAIL mid_reset: state=%h ir=%h enb=%b tdo=%b tlr=%b expected F 1 0 0 1",
               jif.state, jif.ir, jif.tdo_enb, jif.tdo, jif.tlr);
    end
    @(negedge clk);
    trst_n = 1'b1;
    pulse(1'b1, 1'b0);
    total++;
    if (jif.state !== 4'hF || jif.ir !== 4'h1) begin
      bad++;
      $display("FAIL mid_after: state=%h ir=%h expected F 1", jif.state, jif.ir);
    end
  endtask

  initial begin
    jif.tck      = 1'b0;
    jif.tms      = 1'b1;
    jif.tdi      = 1'b0;
    jif.user_tdo = 1'b0;
    test_reset();
    test_tlr_all();
    test_idcode();
    test_ir_bypass();
    test_user();
    test_reset_mid_ir();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
